// File: rtl/cpu_datapath.sv
// cpu_datapath: accumulator-machine datapath (PC, IR, MDR, ACC and ALU).
// Every register update is qualified by a sequencer strobe. halt freezes
// all registers and suppresses memory writes.
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_en,
    input  logic                pc_load,
    input  logic                jmp,
    input  logic                halt,
    input  logic                memIns_en,
    input  logic                memDa_en,
    input  logic                memDa_we,
    input  logic                accumulator_load,
    input  logic                accumulator_control,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [ADDR_W+2:0]   imem_rdata,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic                dmem_we,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic [2:0]          opcode,
    output logic                is_zero,
    output logic [ADDR_W-1:0]   pc_dbg,
    output logic [DATA_W-1:0]   acc_dbg
);

    localparam int INS_W = 3 + ADDR_W;

    localparam logic [2:0] OP_SKZ = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INS_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] alu_res;

    assign opcode     = ir_q[INS_W-1 -: 3];
    assign operand    = ir_q[ADDR_W-1:0];
    assign pc_inc     = pc_q + ADDR_W'(1);

    assign imem_addr  = pc_q;
    assign dmem_addr  = operand;
    assign dmem_wdata = acc_q;
    // Reset term keeps the write strobe low while registers are held in reset.
    assign dmem_we    = memDa_en & memDa_we & ~halt & ~rst;
    assign is_zero    = (acc_q == '0);
    assign pc_dbg     = pc_q;
    assign acc_dbg    = acc_q;

    // ALU: operand A is the accumulator, operand B is the memory data register.
    always_comb begin
        alu_res = acc_q;
        case (opcode)
            OP_SKZ:  alu_res = acc_q;
            OP_ADD:  alu_res = acc_q + mdr_q;
            OP_AND:  alu_res = acc_q & mdr_q;
            OP_LDA:  alu_res = mdr_q;
            default: alu_res = acc_q;
        endcase
    end

    // Next-state for all registers; everything reads pre-edge values only.
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        mdr_d = mdr_q;
        acc_d = acc_q;
        if (!halt) begin
            if (pc_load) begin
                pc_d = jmp ? operand : pc_inc;
            end else if (pc_en) begin
                pc_d = pc_inc;
            end
            if (memIns_en) begin
                ir_d = imem_rdata;
            end
            if (memDa_en && !memDa_we) begin
                mdr_d = dmem_rdata;
            end
            if (accumulator_load) begin
                acc_d = accumulator_control ? mdr_q : alu_res;
            end
        end
    end

    // Register bank; PC resets to all-ones so the first fetch lands on address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '1;
            ir_q  <= '0;
            mdr_q <= '0;
            acc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mdr_q <= mdr_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed instruction sequences plus randomized strobes,
// checked against an arithmetic reference model of the datapath.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_en, pc_load, jmp, halt;
    logic       memIns_en, memDa_en, memDa_we;
    logic       accumulator_load, accumulator_control;
    logic [4:0] imem_addr, dmem_addr, pc_dbg;
    logic [7:0] imem_rdata, dmem_wdata, dmem_rdata, acc_dbg;
    logic       dmem_we, is_zero;
    logic [2:0] opcode;

    logic [7:0] imem [32];
    logic [7:0] dmem [32];

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_pc, m_ir, m_mdr, m_acc;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    cpu_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .pc_en(pc_en), .pc_load(pc_load), .jmp(jmp), .halt(halt),
        .memIns_en(memIns_en), .memDa_en(memDa_en), .memDa_we(memDa_we),
        .accumulator_load(accumulator_load), .accumulator_control(accumulator_control),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata), .opcode(opcode), .is_zero(is_zero),
        .pc_dbg(pc_dbg), .acc_dbg(acc_dbg)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ins(input int op, input int a);
        return 8'((op << 5) | a);
    endfunction

    task automatic model_reset();
        m_pc  = 31;
        m_ir  = 0;
        m_mdr = 0;
        m_acc = 0;
    endtask

    task automatic chk_outputs();
        chk_val("pc_dbg",     pc_dbg,     m_pc);
        chk_val("imem_addr",  imem_addr,  m_pc);
        chk_val("acc_dbg",    acc_dbg,    m_acc);
        chk_val("dmem_wdata", dmem_wdata, m_acc);
        chk_val("opcode",     opcode,     m_ir / 32);
        chk_val("dmem_addr",  dmem_addr,  m_ir % 32);
        chk_val("is_zero",    is_zero,    (m_acc == 0) ? 1 : 0);
    endtask

    // Drive one cycle of strobes, advance the model across the edge, then compare.
    task automatic run_cycle(input logic pe, input logic pl, input logic jp, input logic hl,
                             input logic ie, input logic de, input logic dw,
                             input logic al, input logic ac);
        int op, opnd, alu, n_pc, n_ir, n_mdr, n_acc;
        bit wr;
        pc_en = pe; pc_load = pl; jmp = jp; halt = hl;
        memIns_en = ie; memDa_en = de; memDa_we = dw;
        accumulator_load = al; accumulator_control = ac;
        op   = m_ir / 32;
        opnd = m_ir % 32;
        case (op)
            3:       alu = (m_acc + m_mdr) % 256;
            4:       alu = m_acc & m_mdr;
            5:       alu = m_mdr;
            default: alu = m_acc;
        endcase
        n_pc = m_pc; n_ir = m_ir; n_mdr = m_mdr; n_acc = m_acc;
        wr = de && dw && !hl;
        if (!hl) begin
            if (pl)      n_pc = jp ? opnd : (m_pc + 1) % 32;
            else if (pe) n_pc = (m_pc + 1) % 32;
            if (ie)          n_ir  = int'(imem[m_pc]);
            if (de && !dw)   n_mdr = int'(dmem[opnd]);
            if (al)          n_acc = ac ? m_mdr : alu;
        end
        #1;
        chk_val("dmem_we", dmem_we, wr);
        @(posedge clk);
        if (wr) dmem[opnd] = 8'(m_acc);
        m_pc = n_pc; m_ir = n_ir; m_mdr = n_mdr; m_acc = n_acc;
        #1;
        chk_outputs();
    endtask

    // shorthand strobe patterns
    task automatic do_fetch();   run_cycle(1,0,0,0, 0,0,0, 0,0); endtask
    task automatic do_decode();  run_cycle(0,0,0,0, 1,0,0, 0,0); endtask
    task automatic do_read();    run_cycle(0,0,0,0, 0,1,0, 0,0); endtask
    task automatic do_acc(input logic ac); run_cycle(0,0,0,0, 0,0,0, 1,ac); endtask

    initial begin
        int save_pc, save_acc, save_op;
        for (int i = 0; i < 32; i++) begin
            imem[i] = 8'($urandom);
            dmem[i] = 8'($urandom);
        end
        pc_en = 0; pc_load = 0; jmp = 0; halt = 0;
        memIns_en = 0; memDa_en = 0; memDa_we = 0;
        accumulator_load = 0; accumulator_control = 0;
        rst = 1'b1;
        model_reset();
        #13;
        chk_val("rst_pc", pc_dbg, 5'h1F);
        chk_val("rst_acc", acc_dbg, 0);
        chk_val("rst_op", opcode, 0);
        chk_val("rst_zero", is_zero, 1);
        rst = 1'b0;

        // LDA 10 then ADD 11 with wrap, then AND 12 to clear ACC
        imem[0] = ins(5, 10); imem[1] = ins(3, 11); imem[2] = ins(4, 12); imem[3] = ins(2, 0);
        dmem[10] = 8'hF0; dmem[11] = 8'h20; dmem[12] = 8'h00;
        do_fetch(); chk_val("first_fetch", imem_addr, 0);
        do_decode(); do_read(); do_acc(0);
        chk_val("lda_acc", acc_dbg, 8'hF0);
        do_fetch(); do_decode(); do_read(); do_acc(0);
        chk_val("add_acc", acc_dbg, 8'h10);
        chk_val("add_zero", is_zero, 0);
        do_fetch(); do_decode(); do_read(); do_acc(0);
        chk_val("and_zero", is_zero, 1);

        // SKZ at PC 3: skip via pc_load/jmp=0, then pc_load+pc_en together
        do_fetch(); do_decode();
        chk_val("skz_pc0", pc_dbg, 3);
        run_cycle(0,1,0,0, 0,0,0, 0,0);
        chk_val("skz_pc1", pc_dbg, 4);
        run_cycle(1,1,0,0, 0,0,0, 0,0);
        chk_val("skz_both", pc_dbg, 5);

        // JMP 17, then JMP 31 and increment wrap to 0
        imem[5] = ins(7, 17); imem[17] = ins(7, 31);
        do_decode(); run_cycle(0,1,1,0, 0,0,0, 0,0);
        chk_val("jmp17", pc_dbg, 17);
        do_decode(); run_cycle(0,1,1,0, 0,0,0, 0,0);
        chk_val("jmp31", pc_dbg, 31);
        do_fetch();
        chk_val("pc_wrap", pc_dbg, 0);

        // STO 9 with ACC = 3C; MDR must not load during the write
        dmem[10] = 8'h3C; dmem[9] = 8'h77; imem[1] = ins(6, 9);
        do_decode(); do_read(); do_acc(1);
        chk_val("sto_acc", acc_dbg, 8'h3C);
        do_fetch(); do_decode();
        memDa_en = 1; memDa_we = 1; #1;
        chk_val("sto_we", dmem_we, 1);
        chk_val("sto_addr", dmem_addr, 9);
        chk_val("sto_wdata", dmem_wdata, 8'h3C);
        run_cycle(0,0,0,0, 0,1,1, 0,0);
        chk_val("sto_mem", dmem[9], 8'h3C);
        do_acc(1);
        chk_val("sto_mdr", acc_dbg, 8'h3C);

        // Halt with every strobe raised for 5 cycles
        save_pc = m_pc; save_acc = m_acc; save_op = m_ir / 32;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1,0,0,1, 1,1,1, 1,0);
            chk_val("halt_pc", pc_dbg, save_pc);
            chk_val("halt_acc", acc_dbg, save_acc);
            chk_val("halt_op", opcode, save_op);
        end
        do_acc(1);
        chk_val("halt_mdr", acc_dbg, 8'h3C);

        // Build ACC = 5A at PC 7, then reset mid-run
        dmem[20] = 8'h5A; imem[m_pc] = ins(5, 20);
        do_decode(); do_read(); do_acc(1);
        imem[m_pc] = ins(7, 7);
        do_decode(); run_cycle(0,1,1,0, 0,0,0, 0,0);
        chk_val("pre_rst_pc", pc_dbg, 7);
        chk_val("pre_rst_acc", acc_dbg, 8'h5A);
        #2;
        memDa_en = 1; memDa_we = 1; accumulator_load = 1;
        rst = 1'b1;
        #1;
        model_reset();
        chk_val("mid_rst_acc", acc_dbg, 0);
        chk_val("mid_rst_pc", pc_dbg, 5'h1F);
        chk_val("mid_rst_zero", is_zero, 1);
        chk_val("mid_rst_we", dmem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        do_fetch();
        chk_val("restart_addr", imem_addr, 0);

        // Randomized strobes
        for (int i = 0; i < 600; i++) begin
            run_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Accumulator-machine datapath that sits directly downstream of the 4-state CPU sequencer. It holds the program counter, the instruction register, the memory data register and the accumulator, and contains the ALU. It drives the instruction- and data-memory ports, and returns `opcode` and `is_zero` to the sequencer. Every register update is qualified by the sequencer's strobes. The block makes no sequencing decisions of its own.

## Interface
Parameters:
- DATA_W, 8, accumulator / data-memory word width
- ADDR_W, 5, PC and operand-address width; instruction word = 3 + ADDR_W bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_en  in  1  increment PC
- pc_load  in  1  load PC (jump or skip)
- jmp  in  1  pc_load source select: 1 = IR operand, 0 = PC+1 (skip)
- halt  in  1  freeze all datapath registers
- memIns_en  in  1  capture imem_rdata into IR
- memDa_en  in  1  data-memory access enable
- memDa_we  in  1  data-memory write (valid only with memDa_en)
- accumulator_load  in  1  load ACC
- accumulator_control  in  1  ACC source: 1 = MDR, 0 = ALU result
- imem_addr  out  ADDR_W  = PC
- imem_rdata  in  3+ADDR_W  instruction word; asynchronous read of imem_addr
- dmem_addr  out  ADDR_W  = IR[ADDR_W-1:0]
- dmem_wdata  out  DATA_W  = ACC
- dmem_we  out  1  = memDa_en & memDa_we & !halt
- dmem_rdata  in  DATA_W  asynchronous read of dmem_addr
- opcode  out  3  = IR[top 3 bits]
- is_zero  out  1  = (ACC == 0), combinational from the register
- pc_dbg, acc_dbg  out  ADDR_W, DATA_W  register observation

## Operation
- Registers and reset values:
  - PC = all-ones (pre-increment PC, so the first FETCH increments to address 0).
  - IR = 0, which makes opcode 0 (HALT).
  - MDR = 0.
  - ACC = 0, which makes is_zero = 1 out of reset.
  - dmem_we = 0 during reset.
- PC:
  - If pc_load: PC <= (jmp ? IR operand : PC+1).
  - Else if pc_en: PC <= PC+1.
  - pc_load has priority over pc_en.
  - Increment wraps modulo 2^ADDR_W.
- IR: loads imem_rdata when memIns_en.
- MDR: loads dmem_rdata when memDa_en & !memDa_we.
- ALU, by opcode, with A = ACC and B = MDR:
  - 2 (SKZ) → A
  - 3 (ADD) → A+B, carry discarded, wraps modulo 2^DATA_W
  - 4 (AND) → A&B
  - 5 (LDA) → B
  - all other opcodes → A
- ACC: when accumulator_load, ACC <= (accumulator_control ? MDR : ALU).
- halt = 1 blocks every register write and dmem_we in the same cycle. Outputs hold their values.
- All registered updates occur on the same edge. Each register reads only pre-edge values: IR load and PC load in the same cycle use the old IR operand.

## Timing
- Every register: one-cycle latency from its strobe.
- Combinational outputs (imem_addr, dmem_addr, dmem_wdata, opcode, is_zero) follow registers with zero cycles of latency.
- Typical instruction with sequencer states FETCH/DECODE/EXECUTE/WRITEBACK:
  - FETCH edge: PC+1.
  - DECODE edge: IR loaded.
  - EXECUTE edge: MDR captures mem[operand].
  - WRITEBACK edge: ACC updated, or memory written for STO.
- STO write occurs on every edge where dmem_we = 1. Repeated writes of the same value are allowed.
- Simultaneous memDa_en & memDa_we: MDR holds its value and is not loaded.
- Simultaneous halt with any strobe: halt wins.
- Reset asserted mid-instruction: all registers return to their reset values immediately and asynchronously. After deassertion, execution restarts from address 0.

## Test plan
- Reset: assert rst mid-run with ACC = 8'h5A and PC = 7 → immediately acc_dbg = 0, pc_dbg = 5'h1F, is_zero = 1, dmem_we = 0. First pc_en after release → imem_addr = 0.
- LDA/ADD wrap:
  - imem: {LDA 10, ADD 11}, mem[10] = 8'hF0, mem[11] = 8'h20.
  - After LDA: ACC = 8'hF0.
  - After ADD: ACC = 8'h10, is_zero = 0.
- SKZ: ACC = 0 at PC = 3, then pc_load = 1 with jmp = 0 → PC = 4. With pc_load and pc_en both high → PC still +1 once, not +2.
- JMP and wrap:
  - IR = {7, 5'd17}, pc_load = 1, jmp = 1 → PC = 17.
  - PC = 31 with pc_en → PC = 0.
- STO: ACC = 8'h3C, IR operand 9, memDa_en = 1 and memDa_we = 1 → dmem_we = 1, dmem_addr = 9, dmem_wdata = 8'h3C, MDR unchanged.
- Halt: halt = 1 with pc_en, accumulator_load, memIns_en and memDa_we all high for 5 cycles → PC, IR, ACC and MDR unchanged, dmem_we = 0 throughout.
